matrix_store_responder: RTL and testbench
=========================================

// Module: matrix_store_responder
// PURPOSE
//  Responder end of the coprocessor matrix-access bus. Holds matrices A, B and C
//  (size x size cells each). Serves cell, row and column reads, gathering one cell
//  per cycle, and commits single-cycle cell writes. Sits between the memory-side
//  ports of the matrix engines and local storage.
// PARAMETERS
//  size          4                 matrix dimension (cells per row/column)
//  cell_width    32                bits per cell
//  address_width 4                 cell address bits (row*size + col)
//  width         cell_width*size   bus width of in_data / out_data
// PORTS
//  in_clk          in   1              single clock; all logic on posedge
//  in_reset        in   1              synchronous, active-high reset
//  in_reg_address  in   address_width  cell: row*size+col; row: row*size; col: col
//  in_type         in   2              00 cell, 01 row, 10 column, 11 invalid
//  in_matrix       in   2              00 A, 01 B, 10 C, 11 invalid
//  in_read_en      in   1              read request; held high until out_data_ready seen
//  in_write_en     in   1              one-cycle cell write strobe
//  in_data         in   width          write data; only [cell_width-1:0] used
//  out_data        out  width          read data, valid while out_data_ready=1
//  out_data_ready  out  1              one-cycle read-complete pulse
//  out_error       out  1              one-cycle pulse: request rejected
//  out_busy        out  1              high in any state other than S_IDLE
// BEHAVIOUR
//  Reset (sync, high): every output 0, state S_IDLE, counter 0, all storage cells 0.
//   Reset wins over any request in the same cycle; a read in flight is abandoned.
//  States: S_IDLE, S_GATHER, S_READY, S_RELEASE.
//  S_IDLE: read_en=1 & write_en=0 & request valid -> latch addr/type/matrix,
//   clear out_data, cnt<=0, go S_GATHER.
//   read_en=1 & invalid request -> out_data=0, out_error=1, out_data_ready=1,
//   go S_READY directly.
//   write_en=1 & read_en=0: if type=00, matrix!=11, addr<size*size -> cell <=
//   in_data[cell_width-1:0] at this edge; otherwise drop it and pulse out_error.
//   read_en=1 & write_en=1 together -> neither performed, out_error pulse, stay S_IDLE.
//  Valid read: matrix!=11; cell: addr<size*size; row: addr%size==0 and
//   addr<size*size; column: addr<size.
//  S_GATHER: one cell per edge into out_data[cnt*cell_width +: cell_width].
//   Row k-th cell = addr+k; column k-th cell = addr+k*size; cell read = addr into
//   slot 0, upper bits 0. Gather length n = 1 (cell) or size (row/column).
//   On the n-th edge: out_data_ready<=1, go S_READY.
//  Latency: read_en sampled at edge E0 -> ready visible after edge E0+n.
//  S_READY: ready/error held exactly one cycle, then cleared; out_data is held;
//   go S_RELEASE.
//  S_RELEASE: wait for read_en=0, then go S_IDLE. A request is never re-served
//   while read_en stays high after completion, so the initiator must drop it.
//  Writes arriving outside S_IDLE are dropped and pulse out_error (storage unchanged).
//  Address arithmetic uses address_width bits; indices never wrap, because
//   out-of-range requests are rejected first.
// TESTING
//  1 Reset, then read A cell 5 -> ready after 1 edge, out_data=0, out_error=0.
//  2 Write A cells 4..7 = 1,2,3,4; row read A addr 4 -> ready 4 edges after
//    request, out_data={4,3,2,1} (cell 4 in bits [31:0]), pulse exactly 1 cycle.
//  3 Write B cells 1,5,9,13 = 10,20,30,40; column read B addr 1 ->
//    out_data={40,30,20,10}; read_en held 3 more cycles -> no second ready.
//  4 Row read addr 5 (5%4!=0), column addr 4, and matrix 11 -> each gives
//    out_error=1, out_data_ready=1, out_data=0, storage unchanged.
//  5 Write C cell 3 = 0xDEADBEEF during S_GATHER -> out_error, C[3] still 0;
//    read_en & write_en together in S_IDLE -> out_error, no write, no read.
//  6 Assert in_reset mid row gather -> next cycle all outputs 0, out_busy=0,
//    cells read back 0; new request is served normally.

Source files
------------

// File: rtl/matrix_store_responder.sv
// Matrix store responder: holds matrices A, B and C, serves cell/row/column
// reads by gathering one cell per cycle, and commits single-cycle cell writes.
module matrix_store_responder #(
   parameter int size          = 4,
   parameter int cell_width    = 32,
   parameter int address_width = 4,
   parameter int width         = cell_width * size
) (
   input  logic                     in_clk,
   input  logic                     in_reset,
   input  logic [address_width-1:0] in_reg_address,
   input  logic [1:0]               in_type,
   input  logic [1:0]               in_matrix,
   input  logic                     in_read_en,
   input  logic                     in_write_en,
   input  logic [width-1:0]         in_data,
   output logic [width-1:0]         out_data,
   output logic                     out_data_ready,
   output logic                     out_error,
   output logic                     out_busy
);

   typedef enum logic [1:0] {S_IDLE, S_GATHER, S_READY, S_RELEASE} state_t;

   localparam logic [1:0] T_CELL = 2'b00;
   localparam logic [1:0] T_ROW  = 2'b01;
   localparam logic [1:0] T_COL  = 2'b10;
   localparam logic [1:0] M_NONE = 2'b11;

   localparam int cnt_w = $clog2(size) + 1;
   localparam logic [address_width:0]   n_cells   = (address_width+1)'(size * size);
   localparam logic [address_width:0]   size_ext  = (address_width+1)'(size);
   localparam logic [address_width-1:0] size_addr = address_width'(size);
   localparam logic [cnt_w-1:0]         last_cnt  = cnt_w'(size - 1);

   state_t state, state_nxt;

   // Storage; index 3 (invalid matrix) is never written and stays constant zero.
   logic [cell_width-1:0] mem [4][size*size];

   logic [address_width-1:0] req_addr;
   logic [1:0]               req_type;
   logic [1:0]               req_matrix;
   logic [cnt_w-1:0]         cnt, cnt_nxt;

   logic [width-1:0]         data_nxt;
   logic                     ready_nxt, error_nxt, latch_req, mem_we;

   logic                     in_range, read_ok, write_ok;
   logic [address_width-1:0] gather_idx;
   logic                     gather_last;
   logic [cell_width-1:0]    gather_cell;

   // Only the low cell of in_data carries write data.
   logic unused_data;
   assign unused_data = ^in_data[width-1:cell_width];

   assign out_busy = (state != S_IDLE);

   // Request validation; out-of-range requests are rejected before any indexing.
   always_comb begin
      in_range = ({1'b0, in_reg_address} < n_cells);
      case (in_type)
         T_CELL:  read_ok = in_range;
         T_ROW:   read_ok = in_range && ((in_reg_address % size_addr) == '0);
         T_COL:   read_ok = ({1'b0, in_reg_address} < size_ext);
         default: read_ok = 1'b0;
      endcase
      read_ok  = read_ok && (in_matrix != M_NONE);
      write_ok = (in_type == T_CELL) && (in_matrix != M_NONE) && in_range;
   end

   // Address of the cell gathered this cycle, and whether it is the final one.
   always_comb begin
      case (req_type)
         T_ROW:   gather_idx = req_addr + address_width'(cnt);
         T_COL:   gather_idx = req_addr + address_width'(cnt) * size_addr;
         default: gather_idx = req_addr;
      endcase
      gather_last = (req_type == T_CELL) ? (cnt == '0) : (cnt == last_cnt);
      gather_cell = mem[req_matrix][gather_idx];
   end

   // State register.
   always_ff @(posedge in_clk) begin
      if (in_reset) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:
            if (in_read_en && !in_write_en)
               state_nxt = read_ok ? S_GATHER : S_READY;
         S_GATHER:
            if (gather_last) state_nxt = S_READY;
         S_READY:
            state_nxt = S_RELEASE;
         S_RELEASE:
            if (!in_read_en) state_nxt = S_IDLE;
         default:
            state_nxt = S_IDLE;
      endcase
   end

   // Output/datapath next values; ready and error default low so they pulse.
   always_comb begin
      data_nxt  = out_data;
      ready_nxt = 1'b0;
      error_nxt = 1'b0;
      cnt_nxt   = cnt;
      latch_req = 1'b0;
      mem_we    = 1'b0;
      case (state)
         S_IDLE: begin
            if (in_read_en && in_write_en) begin
               error_nxt = 1'b1;
            end else if (in_read_en) begin
               data_nxt = '0;
               if (read_ok) begin
                  latch_req = 1'b1;
                  cnt_nxt   = '0;
               end else begin
                  error_nxt = 1'b1;
                  ready_nxt = 1'b1;
               end
            end else if (in_write_en) begin
               if (write_ok) mem_we    = 1'b1;
               else          error_nxt = 1'b1;
            end
         end
         S_GATHER: begin
            data_nxt[int'(cnt)*cell_width +: cell_width] = gather_cell;
            cnt_nxt = cnt + 1'b1;
            if (gather_last) ready_nxt = 1'b1;
            if (in_write_en) error_nxt = 1'b1;
         end
         default: begin
            if (in_write_en) error_nxt = 1'b1;
         end
      endcase
   end

   // Datapath registers and storage; reset clears every cell.
   always_ff @(posedge in_clk) begin
      if (in_reset) begin
         out_data       <= '0;
         out_data_ready <= 1'b0;
         out_error      <= 1'b0;
         cnt            <= '0;
         req_addr       <= '0;
         req_type       <= '0;
         req_matrix     <= '0;
         for (int m = 0; m < 4; m++)
            for (int i = 0; i < size*size; i++)
               mem[m][i] <= '0;
      end else begin
         out_data       <= data_nxt;
         out_data_ready <= ready_nxt;
         out_error      <= error_nxt;
         cnt            <= cnt_nxt;
         if (latch_req) begin
            req_addr   <= in_reg_address;
            req_type   <= in_type;
            req_matrix <= in_matrix;
         end
         if (mem_we) mem[in_matrix][in_reg_address] <= in_data[cell_width-1:0];
      end
   end

endmodule

// File: tb/tb_matrix_store_responder.sv
// Directed bench for matrix_store_responder: reads, writes, rejects and reset.
module tb_matrix_store_responder;

   localparam int W = 128;

   logic          in_clk = 1'b0;
   logic          in_reset;
   logic [3:0]    in_reg_address;
   logic [1:0]    in_type;
   logic [1:0]    in_matrix;
   logic          in_read_en;
   logic          in_write_en;
   logic [W-1:0]  in_data;
   logic [W-1:0]  out_data;
   logic          out_data_ready;
   logic          out_error;
   logic          out_busy;

   int n_cmp = 0;
   int n_bad = 0;

   matrix_store_responder dut (
      .in_clk(in_clk), .in_reset(in_reset), .in_reg_address(in_reg_address),
      .in_type(in_type), .in_matrix(in_matrix), .in_read_en(in_read_en),
      .in_write_en(in_write_en), .in_data(in_data), .out_data(out_data),
      .out_data_ready(out_data_ready), .out_error(out_error), .out_busy(out_busy)
   );

   always #5 in_clk = ~in_clk;

   // Advance one edge and settle before sampling.
   task automatic step();
      @(posedge in_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_write(input string tag, input logic [1:0] t, input logic [1:0] m,
                           input logic [3:0] a, input logic [31:0] d, input logic exp_err);
      in_type = t; in_matrix = m; in_reg_address = a; in_data = {96'd0, d};
      in_read_en = 1'b0; in_write_en = 1'b1;
      step();
      chk(tag, out_error, exp_err);
      in_write_en = 1'b0;
   endtask

   // Latency counts edges after the edge that samples the request.
   task automatic do_read(input string tag, input logic [1:0] t, input logic [1:0] m,
                          input logic [3:0] a, input int hold, input int exp_lat,
                          input logic [W-1:0] exp_data, input logic exp_err);
      int lat;
      in_type = t; in_matrix = m; in_reg_address = a;
      in_read_en = 1'b1; in_write_en = 1'b0;
      step();
      chk({tag, " busy"}, out_busy, 1);
      lat = 0;
      while (!out_data_ready && lat < 20) begin
         step();
         lat++;
      end
      chk({tag, " latency"}, lat, exp_lat);
      chk({tag, " data"}, out_data, exp_data);
      chk({tag, " error"}, out_error, exp_err);
      repeat (hold + 1) begin
         step();
         chk({tag, " ready pulse"}, out_data_ready, 0);
      end
      in_read_en = 1'b0;
      step();
      chk({tag, " idle"}, out_busy, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      in_reset = 1'b1; in_reg_address = '0; in_type = '0; in_matrix = '0;
      in_read_en = 1'b0; in_write_en = 1'b0; in_data = '0;
      step(); step();
      chk("rst data", out_data, 0);
      chk("rst ready", out_data_ready, 0);
      chk("rst error", out_error, 0);
      chk("rst busy", out_busy, 0);
      in_reset = 1'b0;
      step();

      // 1: cell read of empty A
      do_read("A cell5", 2'b00, 2'b00, 4'd5, 0, 1, 0, 1'b0);

      // 2: row read of A row 1
      for (int i = 0; i < 4; i++)
         do_write("wr A", 2'b00, 2'b00, 4'(4 + i), 32'(i + 1), 1'b0);
      do_read("A row4", 2'b01, 2'b00, 4'd4, 0, 4, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b0);

      // 3: column read of B col 1, read_en held after completion
      do_write("wr B1", 2'b00, 2'b01, 4'd1, 32'd10, 1'b0);
      do_write("wr B5", 2'b00, 2'b01, 4'd5, 32'd20, 1'b0);
      do_write("wr B9", 2'b00, 2'b01, 4'd9, 32'd30, 1'b0);
      do_write("wr B13", 2'b00, 2'b01, 4'd13, 32'd40, 1'b0);
      do_read("B col1", 2'b10, 2'b01, 4'd1, 3, 4, {32'd40, 32'd30, 32'd20, 32'd10}, 1'b0);

      // 4: rejected reads, storage untouched
      do_read("bad row5", 2'b01, 2'b00, 4'd5, 0, 0, 0, 1'b1);
      do_read("bad col4", 2'b10, 2'b00, 4'd4, 0, 0, 0, 1'b1);
      do_read("bad mat3", 2'b00, 2'b11, 4'd0, 0, 0, 0, 1'b1);
      do_read("bad type3", 2'b11, 2'b00, 4'd0, 0, 0, 0, 1'b1);
      do_read("A row4 again", 2'b01, 2'b00, 4'd4, 0, 4, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b0);

      // 5: write during gather is dropped
      in_type = 2'b01; in_matrix = 2'b10; in_reg_address = 4'd0;
      in_read_en = 1'b1; in_write_en = 1'b0;
      step();
      in_type = 2'b00; in_reg_address = 4'd3; in_data = {96'd0, 32'hDEADBEEF};
      in_write_en = 1'b1;
      step();
      chk("wr in gather error", out_error, 1);
      chk("wr in gather ready", out_data_ready, 0);
      in_write_en = 1'b0;
      step();
      chk("wr in gather error clr", out_error, 0);
      step(); step();
      chk("C row0 ready", out_data_ready, 1);
      chk("C row0 data", out_data, 0);
      step();
      in_read_en = 1'b0;
      step();
      do_read("C cell3", 2'b00, 2'b10, 4'd3, 0, 1, 0, 1'b0);

      // read and write together in idle: rejected, neither happens
      in_type = 2'b00; in_matrix = 2'b00; in_reg_address = 4'd8; in_data = {96'd0, 32'h55};
      in_read_en = 1'b1; in_write_en = 1'b1;
      step();
      chk("rw both error", out_error, 1);
      chk("rw both ready", out_data_ready, 0);
      chk("rw both busy", out_busy, 0);
      in_read_en = 1'b0; in_write_en = 1'b0;
      step();
      chk("rw both error clr", out_error, 0);
      do_read("A cell8", 2'b00, 2'b00, 4'd8, 0, 1, 0, 1'b0);
      do_write("wr mat3", 2'b00, 2'b11, 4'd0, 32'h77, 1'b1);
      do_write("wr type row", 2'b01, 2'b00, 4'd0, 32'h77, 1'b1);
      do_read("A cell0", 2'b00, 2'b00, 4'd0, 0, 1, 0, 1'b0);

      // 6: reset in the middle of a row gather
      in_type = 2'b01; in_matrix = 2'b00; in_reg_address = 4'd4;
      in_read_en = 1'b1; in_write_en = 1'b0;
      step(); step();
      chk("mid gather data", out_data, {96'd0, 32'd1});
      in_reset = 1'b1;
      step();
      chk("mid rst data", out_data, 0);
      chk("mid rst ready", out_data_ready, 0);
      chk("mid rst error", out_error, 0);
      chk("mid rst busy", out_busy, 0);
      in_reset = 1'b0; in_read_en = 1'b0;
      step();
      do_read("A row4 cleared", 2'b01, 2'b00, 4'd4, 0, 4, 0, 1'b0);
      do_read("B col1 cleared", 2'b10, 2'b01, 4'd1, 0, 4, 0, 1'b0);
      do_write("wr A0", 2'b00, 2'b00, 4'd0, 32'd7, 1'b0);
      do_read("A cell0 new", 2'b00, 2'b00, 4'd0, 0, 1, {96'd0, 32'd7}, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
